// File: rtl/he_hssi_mb_bridge.sv
// he_hssi_mb_bridge: host mailbox to Avalon-MM CSR bridge.
// Host software fills ADDR/WRDATA, then writes CMD (0 NOOP, 1 RD, 2 WR, 3 illegal).
// The bridge runs one downstream transaction and posts the result in RDDATA and
// the status bits in CMD (ack, busy, err) for polling.
//
// Optional build macro HSSI_MB_STAT_LATCH_EN: 64-bit statistics reads in the
// 0x3000/0x7000 windows are split into two back-to-back reads. The high word
// is kept in a tagged shadow register that the next RD of that address returns
// without touching the bus.
//
// Downstream handshake: a request (avmm_read/avmm_write) is held with a stable
// address and data until a cycle in which avmm_waitrequest is low. Read data is
// taken only on avmm_readdatavalid, and only while a read is outstanding.
// At most one downstream transaction is in flight at any time.
module he_hssi_mb_bridge #(
    parameter int              AW             = 16,
    parameter int              DW             = 32,
    parameter int              TIMEOUT_CYCLES = 1024,
    parameter logic [DW-1:0]   TO_RDDATA      = DW'(32'hFFFF_FFFF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_wr,
    input  logic            csr_rd,
    input  logic [3:0]      csr_addr,
    input  logic [DW-1:0]   csr_wrdata,
    output logic [DW-1:0]   csr_rddata,
    output logic            csr_rdvalid,
    output logic [AW-1:0]   avmm_address,
    output logic            avmm_read,
    output logic            avmm_write,
    output logic [DW-1:0]   avmm_writedata,
    input  logic            avmm_waitrequest,
    input  logic [DW-1:0]   avmm_readdata,
    input  logic            avmm_readdatavalid,
    output logic            busy,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] CMD_NOOP = 2'd0;
    localparam logic [1:0] CMD_RD   = 2'd1;
    localparam logic [1:0] CMD_WR   = 2'd2;
    localparam logic [1:0] CMD_BAD  = 2'd3;

    localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wrdata_reg;
    logic [DW-1:0]   rddata_reg;
    logic [1:0]      last_cmd;
    logic            ack;
    logic            err;
    logic [TW-1:0]   to_cnt;

    logic            cmd_wr;
    logic            to_hit;
    logic            rd_beat;
    logic [DW-1:0]   cmd_reg;
    logic [DW-1:0]   rd_mux;

`ifdef HSSI_MB_STAT_LATCH_EN
    logic            pair_mode;
    logic            pair_hi;
    logic            tag_valid;
    logic [AW-1:0]   tag_addr;
    logic [DW-1:0]   shadow;
    logic            is_stat_addr;
    logic            shadow_hit;

    // Low word of a 64-bit counter in either MAC statistics window.
    assign is_stat_addr = !addr_reg[2] &&
                          (((addr_reg & ~AW'(8'hFF)) == AW'(16'h3000)) ||
                           ((addr_reg & ~AW'(8'hFF)) == AW'(16'h7000)));
    assign shadow_hit   = tag_valid && (addr_reg == tag_addr);
`endif

    assign dbg_state = state;
    assign cmd_wr    = csr_wr && (csr_addr == 4'h0);
    // Compare with >= so a count that steps past the limit still aborts.
    assign to_hit    = (to_cnt >= TO_LAST);
    // A read beat is accepted with the request or while waiting for data.
    assign rd_beat   = avmm_readdatavalid &&
                       (((state == RD_REQ) && !avmm_waitrequest) || (state == RD_WAIT));
    assign cmd_reg   = {{(DW-5){1'b0}}, err, busy, ack, last_cmd};

    // Host read mux; unmapped offsets return zero.
    always_comb begin
        rd_mux = '0;
        case (csr_addr)
            4'h0:    rd_mux = cmd_reg;
            4'h4:    rd_mux = DW'(addr_reg);
            4'h8:    rd_mux = rddata_reg;
            4'hC:    rd_mux = wrdata_reg;
            default: rd_mux = '0;
        endcase
    end

    // Host side: registered read return and the freely writable ADDR/WRDATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rdvalid <= 1'b0;
            csr_rddata  <= '0;
            addr_reg    <= '0;
            wrdata_reg  <= '0;
        end else begin
            csr_rdvalid <= csr_rd;
            csr_rddata  <= csr_rd ? rd_mux : '0;
            if (csr_wr && (csr_addr == 4'h4)) addr_reg   <= csr_wrdata[AW-1:0];
            if (csr_wr && (csr_addr == 4'hC)) wrdata_reg <= csr_wrdata;
        end
    end

    // Command FSM: accepts CMD writes when idle and drives one downstream transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            ack            <= 1'b0;
            err            <= 1'b0;
            last_cmd       <= CMD_NOOP;
            rddata_reg     <= '0;
            to_cnt         <= '0;
            avmm_address   <= '0;
            avmm_read      <= 1'b0;
            avmm_write     <= 1'b0;
            avmm_writedata <= '0;
`ifdef HSSI_MB_STAT_LATCH_EN
            pair_mode      <= 1'b0;
            pair_hi        <= 1'b0;
            tag_valid      <= 1'b0;
            tag_addr       <= '0;
            shadow         <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (busy) begin
                        // Only a shadow-register hit parks here with busy set.
                        busy <= 1'b0;
                        ack  <= 1'b1;
                    end else if (cmd_wr) begin
                        last_cmd <= csr_wrdata[1:0];
                        ack      <= 1'b0;
                        err      <= 1'b0;
                        to_cnt   <= '0;
                        case (csr_wrdata[1:0])
                            CMD_RD: begin
                                busy <= 1'b1;
`ifdef HSSI_MB_STAT_LATCH_EN
                                tag_valid <= 1'b0;
                                if (shadow_hit) begin
                                    rddata_reg <= shadow;
                                    state      <= DONE;
                                end else begin
                                    pair_mode    <= is_stat_addr;
                                    pair_hi      <= 1'b0;
                                    avmm_address <= addr_reg;
                                    avmm_read    <= 1'b1;
                                    state        <= RD_REQ;
                                end
`else
                                avmm_address <= addr_reg;
                                avmm_read    <= 1'b1;
                                state        <= RD_REQ;
`endif
                            end
                            CMD_WR: begin
                                busy           <= 1'b1;
                                avmm_address   <= addr_reg;
                                avmm_writedata <= wrdata_reg;
                                avmm_write     <= 1'b1;
                                state          <= WR_REQ;
`ifdef HSSI_MB_STAT_LATCH_EN
                                tag_valid      <= 1'b0;
`endif
                            end
                            CMD_BAD: begin
                                ack <= 1'b1;
                                err <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                WR_REQ: begin
                    if (!avmm_waitrequest) begin
                        avmm_write <= 1'b0;
                        busy       <= 1'b0;
                        ack        <= 1'b1;
                        state      <= DONE;
                    end else if (to_hit) begin
                        avmm_write <= 1'b0;
                        busy       <= 1'b0;
                        ack        <= 1'b1;
                        err        <= 1'b1;
                        state      <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end

                RD_REQ, RD_WAIT: begin
                    if (rd_beat) begin
`ifdef HSSI_MB_STAT_LATCH_EN
                        if (pair_mode && !pair_hi) begin
                            // Low word done; go straight on to the high word.
                            rddata_reg   <= avmm_readdata;
                            pair_hi      <= 1'b1;
                            avmm_address <= avmm_address + AW'(4);
                            avmm_read    <= 1'b1;
                            to_cnt       <= to_cnt + TW'(1);
                            state        <= RD_REQ;
                        end else begin
                            if (pair_hi) begin
                                shadow    <= avmm_readdata;
                                tag_addr  <= avmm_address;
                                tag_valid <= 1'b1;
                            end else begin
                                rddata_reg <= avmm_readdata;
                            end
                            avmm_read <= 1'b0;
                            busy      <= 1'b0;
                            ack       <= 1'b1;
                            state     <= DONE;
                        end
`else
                        rddata_reg <= avmm_readdata;
                        avmm_read  <= 1'b0;
                        busy       <= 1'b0;
                        ack        <= 1'b1;
                        state      <= DONE;
`endif
                    end else if (to_hit) begin
                        avmm_read  <= 1'b0;
                        rddata_reg <= TO_RDDATA;
                        busy       <= 1'b0;
                        ack        <= 1'b1;
                        err        <= 1'b1;
                        state      <= DONE;
`ifdef HSSI_MB_STAT_LATCH_EN
                        pair_hi    <= 1'b0;
                        tag_valid  <= 1'b0;
`endif
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                        if ((state == RD_REQ) && !avmm_waitrequest) begin
                            avmm_read <= 1'b0;
                            state     <= RD_WAIT;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_he_hssi_mb_bridge.sv
// Directed bench for he_hssi_mb_bridge: mailbox writes, downstream handshakes,
// timeout abort, busy lock-out, illegal command and optional stat-latch reads.
module tb_he_hssi_mb_bridge;

    logic        clk;
    logic        rst_n;
    logic        csr_wr;
    logic        csr_rd;
    logic [3:0]  csr_addr;
    logic [31:0] csr_wrdata;
    logic [31:0] csr_rddata;
    logic        csr_rdvalid;
    logic [15:0] avmm_address;
    logic        avmm_read;
    logic        avmm_write;
    logic [31:0] avmm_writedata;
    logic        avmm_waitrequest;
    logic [31:0] avmm_readdata;
    logic        avmm_readdatavalid;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    he_hssi_mb_bridge dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .csr_wr             (csr_wr),
        .csr_rd             (csr_rd),
        .csr_addr           (csr_addr),
        .csr_wrdata         (csr_wrdata),
        .csr_rddata         (csr_rddata),
        .csr_rdvalid        (csr_rdvalid),
        .avmm_address       (avmm_address),
        .avmm_read          (avmm_read),
        .avmm_write         (avmm_write),
        .avmm_writedata     (avmm_writedata),
        .avmm_waitrequest   (avmm_waitrequest),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid),
        .busy               (busy),
        .dbg_state          (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // All driver tasks start and end on a falling edge.
    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        csr_wr     = 1'b1;
        csr_addr   = a;
        csr_wrdata = d;
        @(negedge clk);
        csr_wr     = 1'b0;
    endtask

    task automatic csr_read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        csr_rd   = 1'b1;
        csr_addr = a;
        @(negedge clk);
        csr_rd   = 1'b0;
        check({tag, "_rdvalid"}, {31'd0, csr_rdvalid}, 32'd1);
        check(tag, csr_rddata, exp);
    endtask

    initial begin
        rst_n              = 1'b0;
        csr_wr             = 1'b0;
        csr_rd             = 1'b0;
        csr_addr           = 4'h0;
        csr_wrdata         = '0;
        avmm_waitrequest   = 1'b0;
        avmm_readdata      = '0;
        avmm_readdatavalid = 1'b0;

        // ---- reset ----
        repeat (3) @(negedge clk);
        check("rst_avmm_read",  {31'd0, avmm_read},  32'd0);
        check("rst_avmm_write", {31'd0, avmm_write}, 32'd0);
        check("rst_avmm_addr",  {16'd0, avmm_address}, 32'd0);
        check("rst_avmm_wdata", avmm_writedata, 32'd0);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        check("rst_rdvalid",    {31'd0, csr_rdvalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        csr_read_check("rst_cmd",    4'h0, 32'h0);
        csr_read_check("rst_addr",   4'h4, 32'h0);
        csr_read_check("rst_rddata", 4'h8, 32'h0);
        csr_read_check("rst_wrdata", 4'hC, 32'h0);

        // ---- WR with no stall ----
        csr_write(4'h4, 32'h0004);
        csr_write(4'hC, 32'h20);
        csr_write(4'h0, 32'h2);
        check("wr_pulse",   {31'd0, avmm_write}, 32'd1);
        check("wr_addr",    {16'd0, avmm_address}, 32'h0004);
        check("wr_data",    avmm_writedata, 32'h20);
        check("wr_noread",  {31'd0, avmm_read}, 32'd0);
        csr_read_check("wr_cmd_busy", 4'h0, 32'hA);
        check("wr_single",  {31'd0, avmm_write}, 32'd0);
        csr_read_check("wr_cmd_ack", 4'h0, 32'h6);

        // ---- RD with 3 stall cycles, data 2 cycles after acceptance ----
        avmm_waitrequest = 1'b1;
        csr_write(4'h4, 32'h3008);
        csr_write(4'h0, 32'h1);
        check("rd_req",      {31'd0, avmm_read}, 32'd1);
        check("rd_addr",     {16'd0, avmm_address}, 32'h3008);
        check("rd_busy",     {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("rd_req_held", {31'd0, avmm_read}, 32'd1);
        @(negedge clk);
        check("rd_req_held2", {31'd0, avmm_read}, 32'd1);
        avmm_waitrequest = 1'b0;
        @(negedge clk);
        check("rd_req_drop", {31'd0, avmm_read}, 32'd0);
        check("rd_wait_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 32'h1234;
        @(negedge clk);
`ifdef HSSI_MB_STAT_LATCH_EN
        check("rd_pair_req",  {31'd0, avmm_read}, 32'd1);
        check("rd_pair_addr", {16'd0, avmm_address}, 32'h300C);
        avmm_readdata = 32'h0;
        @(negedge clk);
`endif
        avmm_readdatavalid = 1'b0;
        check("rd_done_busy", {31'd0, busy}, 32'd0);
        csr_read_check("rd_cmd",    4'h0, 32'h5);
        csr_read_check("rd_rddata", 4'h8, 32'h1234);

        // ---- WR timeout with waitrequest stuck high ----
        avmm_waitrequest = 1'b1;
        csr_write(4'h4, 32'h0010);
        csr_write(4'hC, 32'h99);
        csr_write(4'h0, 32'h2);
        check("to_req", {31'd0, avmm_write}, 32'd1);
        repeat (1023) @(negedge clk);
        check("to_still_req", {31'd0, avmm_write}, 32'd1);
        @(negedge clk);
        check("to_dropped", {31'd0, avmm_write}, 32'd0);
        check("to_busy",    {31'd0, busy}, 32'd0);
        avmm_waitrequest   = 1'b0;
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 32'hDEAD;
        @(negedge clk);
        avmm_readdatavalid = 1'b0;
        csr_read_check("to_cmd",    4'h0, 32'h16);
        csr_read_check("to_stale",  4'h8, 32'h1234);

        // ---- CMD and ADDR writes while busy ----
        csr_write(4'h4, 32'h0100);
        csr_write(4'h0, 32'h1);
        check("bz_req",  {31'd0, avmm_read}, 32'd1);
        check("bz_addr", {16'd0, avmm_address}, 32'h0100);
        csr_write(4'h4, 32'hBEEF);
        csr_write(4'h0, 32'h1);
        check("bz_ignored",  {31'd0, avmm_read}, 32'd0);
        check("bz_addr_kept", {16'd0, avmm_address}, 32'h0100);
        check("bz_busy",     {31'd0, busy}, 32'd1);
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 32'hCAFE;
        @(negedge clk);
        avmm_readdatavalid = 1'b0;
        check("bz_done", {31'd0, busy}, 32'd0);
        csr_read_check("bz_cmd",    4'h0, 32'h5);
        csr_read_check("bz_rddata", 4'h8, 32'hCAFE);
        csr_read_check("bz_addrreg", 4'h4, 32'hBEEF);

        // ---- illegal command, then NOOP ----
        csr_write(4'h0, 32'h3);
        check("bad_nord", {31'd0, avmm_read},  32'd0);
        check("bad_nowr", {31'd0, avmm_write}, 32'd0);
        csr_read_check("bad_cmd", 4'h0, 32'h17);
        csr_write(4'h0, 32'h0);
        csr_read_check("noop_cmd", 4'h0, 32'h0);

        // ---- unmapped offset and simultaneous read/write ----
        csr_read_check("unmapped", 4'h2, 32'h0);
        csr_wr     = 1'b1;
        csr_rd     = 1'b1;
        csr_addr   = 4'hC;
        csr_wrdata = 32'h55;
        @(negedge clk);
        csr_wr = 1'b0;
        csr_rd = 1'b0;
        check("rw_same_old", csr_rddata, 32'h99);
        csr_read_check("rw_same_new", 4'hC, 32'h55);

`ifdef HSSI_MB_STAT_LATCH_EN
        // ---- atomic 64-bit statistics read ----
        csr_write(4'h4, 32'h7020);
        csr_write(4'h0, 32'h1);
        check("st_lo_req",  {31'd0, avmm_read}, 32'd1);
        check("st_lo_addr", {16'd0, avmm_address}, 32'h7020);
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 32'hAAAA;
        @(negedge clk);
        check("st_hi_req",  {31'd0, avmm_read}, 32'd1);
        check("st_hi_addr", {16'd0, avmm_address}, 32'h7024);
        check("st_hi_busy", {31'd0, busy}, 32'd1);
        avmm_readdata = 32'h5555;
        @(negedge clk);
        avmm_readdatavalid = 1'b0;
        csr_read_check("st_cmd",    4'h0, 32'h5);
        csr_read_check("st_rddata", 4'h8, 32'hAAAA);
        csr_write(4'h4, 32'h7024);
        csr_write(4'h0, 32'h1);
        check("sh_nobus", {31'd0, avmm_read}, 32'd0);
        @(negedge clk);
        check("sh_nobus2", {31'd0, avmm_read}, 32'd0);
        csr_read_check("sh_cmd",    4'h0, 32'h5);
        csr_read_check("sh_rddata", 4'h8, 32'h5555);
        csr_write(4'h0, 32'h1);
        check("sh_inval_req",  {31'd0, avmm_read}, 32'd1);
        check("sh_inval_addr", {16'd0, avmm_address}, 32'h7024);
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = 32'h1111;
        @(negedge clk);
        avmm_readdatavalid = 1'b0;
        csr_read_check("sh_inval_rddata", 4'h8, 32'h1111);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/he_hssi_mb_bridge.md
Name: he_hssi_mb_bridge

Overview:
- Mailbox-to-CSR bridge between the host-facing HE-HSSI CSR window and the traffic-controller/MAC register bus.
- Host software writes the target address, write data and a command (NOOP/RD/WR) into mailbox registers.
- The bridge runs a single Avalon-MM transaction downstream and posts the result and status back for polling.
- Sits directly downstream of the host CSR decoder. Serves traffic-controller registers and the RX (0x3000) / TX (0x7000) MAC statistics windows.

Parameters:
- AW, 16, downstream byte address width
- DW, 32, data width (host and downstream)
- TIMEOUT_CYCLES, 1024, max cycles from request assertion to completion before abort
- TO_RDDATA, 32'hFFFF_FFFF, read data returned on timeout

Ports:
- clk  in  1  bridge clock
- rst_n  in  1  reset; asynchronous, active-low
- csr_wr  in  1  host write strobe, single cycle
- csr_rd  in  1  host read strobe, single cycle
- csr_addr  in  4  byte offset within mailbox: 0x0 CMD, 0x4 ADDR, 0x8 RDDATA, 0xC WRDATA
- csr_wrdata  in  DW  host write data
- csr_rddata  out  DW  host read data
- csr_rdvalid  out  1  host read data valid
- avmm_address  out  AW  downstream address
- avmm_read  out  1  downstream read request
- avmm_write  out  1  downstream write request
- avmm_writedata  out  DW  downstream write data
- avmm_waitrequest  in  1  downstream stall
- avmm_readdata  in  DW  downstream read data
- avmm_readdatavalid  in  1  downstream read data valid
- busy  out  1  transaction in flight

Behaviour:
- Reset (async assert, sync deassert by clk): all outputs 0; ADDR, WRDATA and RDDATA registers 0; status bits 0; FSM in IDLE.
- CMD register read format:
  - [1:0] last command
  - [2] ack (done)
  - [3] busy
  - [4] err (timeout or illegal cmd)
  - other bits 0
- Host reads: csr_rdvalid pulses exactly 1 cycle after csr_rd, carrying the register value sampled at the csr_rd cycle. Unmapped offsets read 0.
- Host writes:
  - ADDR and WRDATA are writable at any time.
  - Their values are snapshotted into internal regs when a command is accepted, so later writes do not disturb an in-flight operation.
  - If csr_wr and csr_rd are asserted in the same cycle, both are serviced; the read returns the pre-write value.
- CMD write handling:
  - In IDLE/DONE, CMD=RD(1) or WR(2): clear ack/err, set busy, go to RD_REQ/WR_REQ next cycle.
  - CMD=NOOP(0): clear ack/err, no bus activity.
  - CMD=3: ack=1, err=1, no bus activity.
  - Any CMD write while busy=1 is ignored entirely.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE.
  - WR_REQ: avmm_write=1 with the snapshotted address and data, held until a cycle with avmm_waitrequest=0; then go to DONE.
  - RD_REQ: avmm_read=1, held until avmm_waitrequest=0; then go to RD_WAIT. If avmm_readdatavalid arrives in that same acceptance cycle, complete directly to DONE.
  - RD_WAIT: on avmm_readdatavalid, RDDATA <= avmm_readdata; go to DONE.
  - DONE: busy=0, ack=1 on the next cycle; FSM is then equivalent to IDLE.
- Latency: WR with waitrequest=0 gives the avmm_write pulse 1 cycle after the CMD write and ack visible 2 cycles after it. RD adds the downstream read latency.
- Timeout:
  - The counter resets on command accept and increments every cycle in WR_REQ, RD_REQ and RD_WAIT.
  - At TIMEOUT_CYCLES: drop avmm_read/avmm_write; for a RD, RDDATA <= TO_RDDATA; set err=1, ack=1; go to DONE.
  - A stale avmm_readdatavalid arriving after a timeout is discarded in IDLE/DONE.
- Only one outstanding downstream transaction at any time.

Optional Feature:
- Macro HSSI_MB_STAT_LATCH_EN (compiled in): atomic 64-bit statistics reads.
  - Trigger: a RD whose address lies in 0x3000–0x30FF or 0x7000–0x70FF and has address[2]=0.
  - The bridge issues two back-to-back reads: address, then address+4. Lo goes to RDDATA; hi goes to a shadow register tagged with address+4.
  - Ack is set only after both reads complete. The timeout covers the whole pair.
  - A following RD of exactly the tagged address returns the shadow value with no bus access, acking 2 cycles after the CMD write, and invalidates the tag.
  - Any WR, or a RD of any other address, invalidates the tag.
- Without the macro: every RD is a single downstream read; no shadow register exists.

Test Plan:
- ADDR=0x0004, WRDATA=0x20, CMD=2, waitrequest=0 -> one avmm_write cycle at 0x0004 with data 0x20; CMD readback 0x6 two cycles after the CMD write.
- ADDR=0x3008, CMD=1, waitrequest high for 3 cycles, readdatavalid 2 cycles after acceptance with 0x1234 -> RDDATA=0x1234; CMD readback 0x5.
- CMD=2 with waitrequest stuck high -> abort at cycle 1024; avmm_write dropped; CMD readback 0x16; a late readdatavalid is ignored.
- CMD=1 issued while busy, plus a write of ADDR=0xBEEF mid-read -> second command ignored; the in-flight read keeps its original address.
- CMD=3 -> no avmm activity; CMD readback 0x17. Then CMD=0 -> CMD readback 0x0.
- HSSI_MB_STAT_LATCH_EN: RD 0x7020 (lo 0xAAAA, hi 0x5555) -> two bus reads, RDDATA=0xAAAA. Then RD 0x7024 -> 0x5555 with no bus read. Then RD 0x7024 again -> a real bus read.
